// File: rtl/accumulator_control.sv
// Multicycle Moore control unit for the 16-bit accumulator datapath.
// One 16-state FSM decodes IR[15:12] and sequences PC, memory, ACC/SP and ALU controls.
module accumulator_control (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] Opcode,
  input  logic       Stall,
  output logic       PCWrite,
  output logic       Branch,
  output logic       bneOrbeq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AccWrite,
  output logic       SpWrite,
  output logic [1:0] PCSrc,
  output logic [1:0] MemAddr,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       Illegal,
  output logic       Halted
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StAddr    = 4'd2,
    StMemRd   = 4'd3,
    StAluExe  = 4'd4,
    StStore   = 4'd5,
    StImmExe  = 4'd6,
    StBranch  = 4'd7,
    StJump    = 4'd8,
    StSpDec   = 4'd9,
    StPushWr  = 4'd10,
    StPopAddr = 4'd11,
    StPopRd   = 4'd12,
    StPopWb   = 4'd13,
    StSpInc   = 4'd14,
    StHalt    = 4'd15
  } state_e;

  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluSub   = 3'd1;
  localparam logic [2:0] AluPassB = 3'd4;
  localparam logic [2:0] AluPassA = 3'd5;

  localparam logic [1:0] SrcAPc  = 2'd0;
  localparam logic [1:0] SrcAAcc = 2'd1;
  localparam logic [1:0] SrcASp  = 2'd2;

  localparam logic [2:0] SrcBTwo = 3'd0;
  localparam logic [2:0] SrcBMdr = 3'd1;
  localparam logic [2:0] SrcBSe  = 3'd2;
  localparam logic [2:0] SrcBZe  = 3'd3;
  localparam logic [2:0] SrcBSl1 = 3'd4;

  localparam logic [1:0] AddrAluOut = 2'd1;
  localparam logic [1:0] PcAluOut   = 2'd1;
  localparam logic [1:0] PcJump     = 2'd2;

  state_e state_q, state_d;
  logic   op_illegal;

  assign op_illegal = (Opcode == 4'hC) || (Opcode == 4'hD) || (Opcode == 4'hE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   state_d = Stall ? StFetch : StDecode;
      StDecode: begin
        unique case (Opcode)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: state_d = StAddr;
          4'h6:                               state_d = StImmExe;
          4'h7, 4'h8:                         state_d = StBranch;
          4'h9:                               state_d = StJump;
          4'hA:                               state_d = StSpDec;
          4'hB:                               state_d = StPopAddr;
          4'hF:                               state_d = StHalt;
          default:                            state_d = StFetch;
        endcase
      end
      StAddr:    state_d = (Opcode == 4'h5) ? StStore : StMemRd;
      StMemRd:   state_d = StAluExe;
      StAluExe:  state_d = StFetch;
      StStore:   state_d = StFetch;
      StImmExe:  state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StSpDec:   state_d = StPushWr;
      StPushWr:  state_d = StFetch;
      StPopAddr: state_d = StPopRd;
      StPopRd:   state_d = StPopWb;
      StPopWb:   state_d = StSpInc;
      StSpInc:   state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are gated by reset so an abort drops every strobe without waiting for a clock edge.
  always_comb begin
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    bneOrbeq  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AccWrite  = 1'b0;
    SpWrite   = 1'b0;
    PCSrc     = 2'd0;
    MemAddr   = 2'd0;
    ALUSrcA   = 2'd0;
    ALUSrcB   = 3'd0;
    ALUOp     = 3'd0;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    Halted    = 1'b0;
    State     = state_q;
    if (reset) begin
      unique case (state_q)
        StFetch: begin
          if (!Stall) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcA = SrcAPc;
            ALUSrcB = SrcBTwo;
            ALUOp   = AluAdd;
          end
        end
        StDecode: begin
          ALUSrcA = SrcAPc;
          ALUSrcB = SrcBSl1;
          ALUOp   = AluAdd;
          Illegal = op_illegal;
        end
        StAddr: begin
          ALUSrcB = SrcBZe;
          ALUOp   = AluPassB;
        end
        StMemRd:   MemAddr = AddrAluOut;
        StAluExe: begin
          ALUSrcA   = SrcAAcc;
          ALUSrcB   = SrcBMdr;
          AccWrite  = 1'b1;
          InstrDone = 1'b1;
          ALUOp     = (Opcode == 4'h4) ? AluPassB : {1'b0, Opcode[1:0]};
        end
        StStore, StPushWr: begin
          MemAddr   = AddrAluOut;
          MemWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        StImmExe: begin
          ALUSrcA   = SrcAAcc;
          ALUSrcB   = SrcBSe;
          ALUOp     = AluAdd;
          AccWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        StBranch: begin
          ALUSrcA   = SrcAAcc;
          ALUOp     = AluPassA;
          Branch    = 1'b1;
          bneOrbeq  = Opcode[3];
          PCSrc     = PcAluOut;
          InstrDone = 1'b1;
        end
        StJump: begin
          PCSrc     = PcJump;
          PCWrite   = 1'b1;
          InstrDone = 1'b1;
        end
        StSpDec: begin
          ALUSrcA = SrcASp;
          ALUSrcB = SrcBTwo;
          ALUOp   = AluSub;
          SpWrite = 1'b1;
        end
        StPopAddr: begin
          ALUSrcA = SrcASp;
          ALUOp   = AluPassA;
        end
        StPopRd:   MemAddr = AddrAluOut;
        StPopWb: begin
          ALUSrcB  = SrcBMdr;
          ALUOp    = AluPassB;
          AccWrite = 1'b1;
        end
        StSpInc: begin
          ALUSrcA   = SrcASp;
          ALUSrcB   = SrcBTwo;
          ALUOp     = AluAdd;
          SpWrite   = 1'b1;
          InstrDone = 1'b1;
        end
        StHalt:    Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_control.sv
// Directed bench for accumulator_control: a per-opcode state-sequence model drives
// expected outputs every cycle, with literal pins on the test-plan highlights.
module tb_accumulator_control;

  typedef struct packed {
    logic [3:0] state;
    logic       pcw, br, bne, memw, irw, accw, spw;
    logic [1:0] pcsrc, memaddr, srca;
    logic [2:0] srcb, aluop;
    logic       done, ill, halted;
  } outs_t;

  logic       CLK, reset, Stall;
  logic [3:0] Opcode;
  logic       PCWrite, Branch, bneOrbeq, MemWrite, IRWrite, AccWrite, SpWrite;
  logic [1:0] PCSrc, MemAddr, ALUSrcA;
  logic [2:0] ALUSrcB, ALUOp;
  logic [3:0] State;
  logic       InstrDone, Illegal, Halted;

  accumulator_control dut (
    .CLK(CLK), .reset(reset), .Opcode(Opcode), .Stall(Stall),
    .PCWrite(PCWrite), .Branch(Branch), .bneOrbeq(bneOrbeq), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AccWrite(AccWrite), .SpWrite(SpWrite), .PCSrc(PCSrc),
    .MemAddr(MemAddr), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .State(State), .InstrDone(InstrDone), .Illegal(Illegal), .Halted(Halted)
  );

  outs_t act;
  assign act = {State, PCWrite, Branch, bneOrbeq, MemWrite, IRWrite, AccWrite, SpWrite,
                PCSrc, MemAddr, ALUSrcA, ALUSrcB, ALUOp, InstrDone, Illegal, Halted};

  int    errors = 0;
  int    checks = 0;
  outs_t exp_vec, lit_val, lit_mask;
  bit    exp_valid = 0, lit_valid = 0;
  string exp_name = "", lit_name = "";

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected outputs for a named state of an instruction, straight from the state table.
  function automatic outs_t exp_out(input int st, input logic [3:0] op, input logic stall);
    outs_t o;
    o = '0;
    o.state = st[3:0];
    case (st)
      0:  if (!stall) begin o.irw = 1; o.pcw = 1; end
      1:  begin o.srcb = 3'd4; o.ill = (op >= 4'hC && op <= 4'hE); end
      2:  begin o.srcb = 3'd3; o.aluop = 3'd4; end
      3:  o.memaddr = 2'd1;
      4:  begin
        o.srca = 2'd1; o.srcb = 3'd1; o.accw = 1; o.done = 1;
        o.aluop = (op == 4'h4) ? 3'd4 : op[2:0];
      end
      5:  begin o.memaddr = 2'd1; o.memw = 1; o.done = 1; end
      6:  begin o.srca = 2'd1; o.srcb = 3'd2; o.accw = 1; o.done = 1; end
      7:  begin
        o.srca = 2'd1; o.aluop = 3'd5; o.br = 1; o.bne = op[3]; o.pcsrc = 2'd1; o.done = 1;
      end
      8:  begin o.pcsrc = 2'd2; o.pcw = 1; o.done = 1; end
      9:  begin o.srca = 2'd2; o.aluop = 3'd1; o.spw = 1; end
      10: begin o.memaddr = 2'd1; o.memw = 1; o.done = 1; end
      11: begin o.srca = 2'd2; o.aluop = 3'd5; end
      12: o.memaddr = 2'd1;
      13: begin o.srcb = 3'd1; o.aluop = 3'd4; o.accw = 1; end
      14: begin o.srca = 2'd2; o.spw = 1; o.done = 1; end
      15: o.halted = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic seq_of(input logic [3:0] op, output int s[8], output int n);
    s = '{default: 0};
    s[1] = 1;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin s[2] = 2; s[3] = 3; s[4] = 4; n = 5; end
      4'h5:       begin s[2] = 2; s[3] = 5; n = 4; end
      4'h6:       begin s[2] = 6; n = 3; end
      4'h7, 4'h8: begin s[2] = 7; n = 3; end
      4'h9:       begin s[2] = 8; n = 3; end
      4'hA:       begin s[2] = 9; s[3] = 10; n = 4; end
      4'hB:       begin s[2] = 11; s[3] = 12; s[4] = 13; s[5] = 14; n = 6; end
      4'hF:       begin s[2] = 15; n = 3; end
      default:    n = 2;
    endcase
  endtask

  always @(negedge CLK) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_vec) begin
        errors++;
        $display("FAIL %s: got %h want %h (t=%0t)", exp_name, act, exp_vec, $time);
      end
    end
    if (lit_valid) begin
      checks++;
      if ((act & lit_mask) !== lit_val) begin
        errors++;
        $display("FAIL %s: got %h want %h under mask %h", lit_name, act & lit_mask, lit_val,
                 lit_mask);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input int st, input string nm);
    exp_vec   = exp_out(st, Opcode, Stall);
    exp_name  = nm;
    exp_valid = 1;
    lit_valid = 0;
  endtask

  task automatic run_instr(input logic [3:0] op, input string nm, input int pin_k,
                           input outs_t pv, input outs_t pm, input bit mid_stall);
    int s[8];
    int n;
    seq_of(op, s, n);
    Opcode = op;
    for (int k = 0; k < n; k++) begin
      if (mid_stall && k == 1) Stall = 1'b1;
      step(s[k], nm);
      if (k == pin_k) begin
        lit_val = pv; lit_mask = pm; lit_name = {nm, "_pin"}; lit_valid = 1;
      end
      tick();
    end
  endtask

  outs_t pv, pm;

  initial begin
    reset = 1'b0; Stall = 1'b0; Opcode = 4'h0;
    exp_vec = '0; exp_name = "reset_zero"; exp_valid = 1;
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b1;

    pv = '0; pv.pcw = 1; pv.irw = 1;
    pm = '0; pm.state = '1; pm.pcw = 1; pm.irw = 1;
    run_instr(4'h1, "sub_first_fetch", 0, pv, pm, 0);

    pv = '0; pv.state = 4'd4; pv.srcb = 3'd1; pv.accw = 1; pv.done = 1;
    pm = '0; pm.state = '1; pm.aluop = '1; pm.srcb = '1; pm.accw = 1; pm.done = 1;
    run_instr(4'h0, "add", 4, pv, pm, 0);
    run_instr(4'h2, "and", -1, '0, '0, 0);
    run_instr(4'h3, "or", -1, '0, '0, 0);
    run_instr(4'h4, "lda", -1, '0, '0, 0);

    pv = '0; pv.state = 4'd5; pv.memw = 1;
    pm = '0; pm.state = '1; pm.memw = 1;
    run_instr(4'h5, "sta", 3, pv, pm, 0);
    run_instr(4'h7, "beq", -1, '0, '0, 0);

    pv = '0; pv.state = 4'd7; pv.br = 1; pv.bne = 1; pv.pcsrc = 2'd1;
    pm = '0; pm.state = '1; pm.br = 1; pm.bne = 1; pm.pcsrc = '1;
    run_instr(4'h8, "bne", 2, pv, pm, 0);
    run_instr(4'h9, "jmp", -1, '0, '0, 0);
    run_instr(4'hA, "push", -1, '0, '0, 0);

    pv = '0; pv.state = 4'd14; pv.spw = 1;
    pm = '0; pm.state = '1; pm.spw = 1; pm.aluop = '1;
    run_instr(4'hB, "pop", 5, pv, pm, 0);
    run_instr(4'hC, "illegal_c", -1, '0, '0, 0);

    pv = '0; pv.state = 4'd1; pv.ill = 1;
    pm = '0; pm.state = '1; pm.ill = 1; pm.pcw = 1; pm.memw = 1; pm.irw = 1;
    pm.accw = 1; pm.spw = 1; pm.done = 1;
    run_instr(4'hD, "illegal_d", 1, pv, pm, 0);
    run_instr(4'hE, "illegal_e", -1, '0, '0, 0);

    // Stall raised mid-ADDI must not disturb it; then it holds FETCH for 4 cycles.
    run_instr(4'h6, "addi_mid_stall", -1, '0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, "stall_hold");
      if (i == 2) begin
        lit_val = '0; lit_mask = '1; lit_name = "stall_zero_pin"; lit_valid = 1;
      end
      tick();
    end
    Stall = 1'b0;
    run_instr(4'h9, "jmp_after_stall", -1, '0, '0, 0);

    // Abort an ADD in MEMRD: outputs must fall before the next clock edge.
    Opcode = 4'h0;
    step(0, "abort_fetch"); tick();
    step(1, "abort_decode"); tick();
    step(2, "abort_addr"); tick();
    exp_vec = '0; exp_name = "async_reset";
    #1 reset = 1'b0;
    tick();
    exp_vec = '0; exp_name = "async_reset_hold";
    tick();
    reset = 1'b1;
    run_instr(4'h4, "lda_after_abort", -1, '0, '0, 0);

    run_instr(4'hF, "halt_entry", -1, '0, '0, 0);
    for (int i = 0; i < 20; i++) begin
      Stall  = 1'($urandom_range(1, 0));
      Opcode = 4'($urandom_range(15, 0));
      step(15, "halt_hold");
      if (i == 10) begin
        lit_val = '0; lit_val.state = 4'd15; lit_val.halted = 1;
        lit_mask = '1; lit_name = "halt_pin"; lit_valid = 1;
      end
      tick();
    end
    Stall = 1'b0;
    reset = 1'b0;
    exp_vec = '0; exp_name = "halt_reset"; lit_valid = 0;
    tick();
    reset = 1'b1;
    run_instr(4'h6, "addi_after_halt", -1, '0, '0, 0);

    exp_valid = 0;
    lit_valid = 0;
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
